mem_arbiter_ooo_flush: RTL

- N-to-1 memory request arbiter with in-order response routing and per-master response squashing.
- Generalises the fixed 2-master arbiter: parametrised master count and depth, selectable fixed-priority or round-robin policy, per-master flush that discards in-flight responses.
- Sits between the fetch/execute memory ports and the external memory interface. Fetch can flush on a branch without draining stale responses into the pipeline.

---
 rtl/mem_arbiter_ooo_flush.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter_ooo_flush.sv
// mem_arbiter_ooo_flush
// ---------------------------------------------------------------------------
// N-to-1 memory request arbiter. Requests from CNT masters are forwarded to a
// single slave port with zero added latency. Every accepted request records
// {master id, drop} in an outstanding FIFO so that slave responses, which
// arrive in request order, are routed back to the master that issued them.
// A per-master flush marks that master's outstanding entries as dropped; their
// responses are consumed from the slave without being shown to any master.
//
// Parameters : CNT (masters, 1..8), REQ_W, RESP_W, QUEUE_DEPTH (outstanding
//              requests, power of 2), PRIO_MODE (0 fixed priority, 1 RR).
// Ports      : clk, rst (async, active-high)
//              m_req_valid/m_req_ready/m_req_data   per-master request side
//              m_resp_valid/m_resp_ready/m_resp_data response side (data shared)
//              flush                                per-master response discard
//              s_req_*/s_resp_*                      slave memory interface
// Optional   : MEM_ARB_STATS_EN adds stat_grants (CNT x 32-bit saturating
//              grant counters) and stat_squashed (32-bit saturating count of
//              discarded responses).
// ---------------------------------------------------------------------------
module mem_arbiter_ooo_flush #(
  parameter int CNT         = 2,
  parameter int REQ_W       = 64,
  parameter int RESP_W      = 32,
  parameter int QUEUE_DEPTH = 2,
  parameter int PRIO_MODE   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT-1:0]       m_req_valid,
  output logic [CNT-1:0]       m_req_ready,
  input  logic [CNT*REQ_W-1:0] m_req_data,
  output logic [CNT-1:0]       m_resp_valid,
  input  logic [CNT-1:0]       m_resp_ready,
  output logic [RESP_W-1:0]    m_resp_data,
  input  logic [CNT-1:0]       flush,
  output logic                 s_req_valid,
  input  logic                 s_req_ready,
  output logic [REQ_W-1:0]     s_req_data,
  input  logic                 s_resp_valid,
  output logic                 s_resp_ready,
  input  logic [RESP_W-1:0]    s_resp_data
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [CNT*32-1:0]    stat_grants,
  output logic [31:0]          stat_squashed
`endif
);

  localparam int IW = (CNT > 1) ? $clog2(CNT) : 1;
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic [IW-1:0]          fifo_id [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] fifo_drop;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          lock_idx;
  logic                   lock;
  logic [IW-1:0]          sel;
  logic                   full;
  logic                   fire;
  logic                   head_valid;
  logic [IW-1:0]          head_id;
  logic                   squash;
  logic                   pop;

  // Circular pointer advance that also works for non-power-of-2 wrap points.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(QUEUE_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + 1'b1;
    end
  endfunction

  // Grant selection: a stalled request keeps its master so the slave sees a
  // stable payload; otherwise the lowest index (or first from rr_ptr) wins.
  always_comb begin
    sel = '0;
    if (lock) begin
      sel = lock_idx;
    end else if (PRIO_MODE == 0) begin
      // Descending scan: the last hit is the lowest valid index.
      for (int i = CNT - 1; i >= 0; i--) begin
        sel = m_req_valid[i] ? IW'(i) : sel;
      end
    end else begin
      sel = rr_ptr;
      for (int k = CNT - 1; k >= 0; k--) begin
        sel = m_req_valid[(int'(rr_ptr) + k) % CNT] ? IW'((int'(rr_ptr) + k) % CNT) : sel;
      end
    end
  end

  // Request path straight through to the slave; outputs held low in reset.
  always_comb begin
    full        = (count == CW'(QUEUE_DEPTH));
    s_req_data  = m_req_data[int'(sel)*REQ_W +: REQ_W];
    m_req_ready = '0;
    if (rst) begin
      s_req_valid = 1'b0;
    end else begin
      s_req_valid = (|m_req_valid) && !full;
      for (int i = 0; i < CNT; i++) begin
        m_req_ready[i] = (sel == IW'(i)) && s_req_ready && !full;
      end
    end
    fire = s_req_valid && s_req_ready;
  end

  // Response routing from the FIFO head; a flush squashes the head at once.
  always_comb begin
    head_valid   = (count != '0);
    head_id      = fifo_id[rd_ptr];
    squash       = head_valid && (fifo_drop[rd_ptr] || flush[head_id]);
    m_resp_data  = s_resp_data;
    m_resp_valid = '0;
    if (rst || !head_valid) begin
      s_resp_ready = 1'b0;
    end else if (squash) begin
      s_resp_ready = 1'b1;
    end else begin
      s_resp_ready          = m_resp_ready[head_id];
      m_resp_valid[head_id] = s_resp_valid;
    end
    pop = s_resp_valid && s_resp_ready;
  end

  // Outstanding FIFO, round-robin pointer and stall lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < QUEUE_DEPTH; k++) begin
        fifo_id[k] <= '0;
      end
      fifo_drop <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rr_ptr    <= '0;
      lock      <= 1'b0;
      lock_idx  <= '0;
    end else begin
      // Marking stale slots too is harmless: a push rewrites the drop bit.
      for (int k = 0; k < QUEUE_DEPTH; k++) begin
        if (flush[fifo_id[k]]) begin
          fifo_drop[k] <= 1'b1;
        end
      end
      if (fire) begin
        fifo_id[wr_ptr]   <= sel;
        fifo_drop[wr_ptr] <= flush[sel];
        wr_ptr            <= ptr_next(wr_ptr);
        rr_ptr            <= (sel == IW'(CNT - 1)) ? '0 : sel + 1'b1;
        lock              <= 1'b0;
      end else if (s_req_valid) begin
        lock     <= 1'b1;
        lock_idx <= sel;
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({fire, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Saturating grant and squashed-response counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grants   <= '0;
      stat_squashed <= 32'd0;
    end else begin
      for (int i = 0; i < CNT; i++) begin
        if (fire && (sel == IW'(i)) && (stat_grants[i*32 +: 32] != 32'hFFFF_FFFF)) begin
          stat_grants[i*32 +: 32] <= stat_grants[i*32 +: 32] + 32'd1;
        end
      end
      if (pop && squash && (stat_squashed != 32'hFFFF_FFFF)) begin
        stat_squashed <= stat_squashed + 32'd1;
      end
    end
  end
`endif

endmodule
